prog_loader: RTL and testbench

//  Program-memory front end sitting directly upstream of the CPU instruction bus.

---
 rtl/prog_loader.sv | 92 +++++++++
 tb/tb_prog_loader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Program-memory front end: loads a length-prefixed, XOR-checked byte image into
// program RAM, holds the CPU in reset until the image verifies, then serves fetches.
module prog_loader #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [ADDR_W-1:0] address,
  output logic [7:0]        D_BUS,
  output logic              cpu_rst_n,
  output logic              done,
  output logic              error
);

  // One extra bit so a full-depth image length is representable.
  localparam int LEN_W = ADDR_W + 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(DEPTH);

  typedef enum logic [2:0] {
    IDLE, HDR_HI, HDR_LO, PAYLOAD, CHECK, RUN, ERROR
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] wptr;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] hdr_len;
  logic [7:0]       acc;
  logic [7:0]       mem [DEPTH];
  logic             xfer;
  logic             mem_we;

  assign rx_ready  = (state == HDR_HI) || (state == HDR_LO) ||
                     (state == PAYLOAD) || (state == CHECK);
  assign cpu_rst_n = (state == RUN);
  assign done      = (state == RUN);
  assign error     = (state == ERROR);

  assign xfer    = rx_valid & rx_ready;
  assign hdr_len = LEN_W'({len[11:8], rx_data});
  // A byte arriving alongside a restart belongs to the abandoned image.
  assign mem_we  = xfer && (state == PAYLOAD) && !load_start;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      wptr  <= '0;
      len   <= '0;
      acc   <= '0;
    end else if (load_start) begin
      state <= HDR_HI;
      wptr  <= '0;
      acc   <= '0;
    end else if (xfer) begin
      unique case (state)
        HDR_HI: begin
          len   <= LEN_W'({rx_data[3:0], 8'h00});
          state <= (rx_data[7:4] != 4'h0) ? ERROR : HDR_LO;
        end
        HDR_LO: begin
          len   <= hdr_len;
          state <= (hdr_len == '0 || hdr_len > DEPTH_LEN) ? ERROR : PAYLOAD;
        end
        PAYLOAD: begin
          acc  <= acc ^ rx_data;
          wptr <= wptr + LEN_W'(1);
          if (wptr == len - LEN_W'(1)) state <= CHECK;
        end
        CHECK: state <= (rx_data == acc) ? RUN : ERROR;
        default: state <= state;
      endcase
    end
  end

  // NOTE: the program RAM is deliberately not reset; clearing it would forbid
  // a RAM macro and contents are only visible after a verified load anyway.
  always_ff @(posedge clock) begin
    if (mem_we) mem[wptr[IDX_W-1:0]] <= rx_data;
  end

  // Zero-latency read so the CPU sees ROM-like fetch timing.
  assign D_BUS = ((state == RUN) && (LEN_W'(address) < len)) ?
                 mem[address[IDX_W-1:0]] : 8'h00;

endmodule

// File: tb/tb_prog_loader.sv
// Directed-plus-random bench for prog_loader; a reference model of the RAM image
// and load outcome predicts every observed output.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [11:0] address = 12'h000;
  logic        rx_ready, cpu_rst_n, done, error;
  logic [7:0]  d_bus;
  logic        s_rx_ready, s_cpu_rst_n, s_done, s_error;
  logic [7:0]  s_d_bus;

  int vectors = 0;
  int miscompares = 0;
  bit gaps = 0;

  logic [7:0] model_mem [4096];
  logic [7:0] pay [4096];
  int         run_len = 0;
  bit         model_run = 0;

  always #5 clk = ~clk;

  prog_loader dut (
    .clock(clk), .reset(rst_n), .load_start(load_start), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .address(address), .D_BUS(d_bus),
    .cpu_rst_n(cpu_rst_n), .done(done), .error(error)
  );

  prog_loader #(.ADDR_W(12), .DEPTH(256)) dut_small (
    .clock(clk), .reset(rst_n), .load_start(load_start), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(s_rx_ready), .address(address), .D_BUS(s_d_bus),
    .cpu_rst_n(s_cpu_rst_n), .done(s_done), .error(s_error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_dbus(input int a);
    return (model_run && a < run_len) ? model_mem[a] : 8'h00;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n;
    bit ok;
    if (gaps && $urandom_range(0, 2) == 0) begin
      rx_valid = 1'b0;
      tick();
    end
    rx_data  = b;
    rx_valid = 1'b1;
    ok = 0;
    n = 0;
    while (!ok && n < 20) begin
      if (rx_ready) ok = 1;
      tick();
      n++;
    end
    rx_valid = 1'b0;
    if (!ok) check("rx_ready_timeout", 0, 1);
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    model_run = 0;
  endtask

  // Full load of header + pay[0..len-1] + checksum; returns the model's verdict.
  task automatic load_image(input logic [7:0] hi, input logic [7:0] lo,
                            input logic [7:0] csum, output bit good);
    int len;
    logic [7:0] x;
    len = {hi[3:0], lo};
    good = 0;
    pulse_start();
    send_byte(hi);
    if (hi[7:4] != 4'h0) return;
    send_byte(lo);
    if (len == 0 || len > 4096) return;
    x = 8'h00;
    for (int i = 0; i < len; i++) begin
      send_byte(pay[i]);
      model_mem[i] = pay[i];
      x ^= pay[i];
    end
    send_byte(csum);
    good = (csum == x);
    if (good) begin
      model_run = 1;
      run_len = len;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit good;
    logic [7:0] x;

    // Reset and idle
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    address = 12'h005;
    #1;
    check("idle_cpu_rst_n", cpu_rst_n, 0);
    check("idle_rx_ready", rx_ready, 0);
    check("idle_d_bus", d_bus, 8'h00);
    check("idle_done", done, 0);
    check("idle_error", error, 0);

    // Small good image
    pay[0] = 8'hA1; pay[1] = 8'hB2; pay[2] = 8'hC3;
    load_image(8'h00, 8'h03, 8'hD0, good);
    check("good_model", good, 1);
    check("good_done", done, 1);
    check("good_cpu_rst_n", cpu_rst_n, 1);
    check("good_error", error, 0);
    for (int a = 0; a < 4; a++) begin
      address = 12'(a);
      #1;
      check($sformatf("good_rd_%0d", a), d_bus, exp_dbus(a));
    end

    // Bad checksum, then recovery
    load_image(8'h00, 8'h03, 8'h00, good);
    address = 12'h000;
    #1;
    check("badck_error", error, !good);
    check("badck_cpu_rst_n", cpu_rst_n, good);
    check("badck_d_bus", d_bus, exp_dbus(0));
    pay[0] = 8'h5A; pay[1] = 8'h0F;
    load_image(8'h00, 8'h02, 8'h55, good);
    #1;
    check("recover_done", done, good);
    check("recover_rd_1", d_bus, exp_dbus(0));

    // Header rejections
    pulse_start();
    check("hdr_ready_after_start", rx_ready, 1);
    send_byte(8'h10);
    check("hdr_upper_nibble_error", error, 1);
    check("hdr_upper_nibble_ready", rx_ready, 0);
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h00);
    check("hdr_zero_len_error", error, 1);
    check("hdr_zero_len_small", s_error, 1);
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h01);
    check("hdr_257_big_ok", error, 0);
    check("hdr_257_big_ready", rx_ready, 1);
    check("hdr_257_small_error", s_error, 1);
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h00);
    check("hdr_256_small_ok", s_error, 0);
    check("hdr_256_small_ready", s_rx_ready, 1);

    // Mid-payload restart with a byte in flight on the restart cycle
    gaps = 1;
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h14);
    for (int i = 0; i < 7; i++) begin
      x = 8'($urandom);
      send_byte(x);
    end
    rx_data = 8'hEE;
    rx_valid = 1'b1;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    rx_valid = 1'b0;
    model_run = 0;
    check("restart_ready", rx_ready, 1);
    check("restart_done", done, 0);

    // Max-length random image with random valid gaps
    x = 8'h00;
    for (int i = 0; i < 4095; i++) begin
      pay[i] = 8'($urandom);
      x ^= pay[i];
    end
    load_image(8'h0F, 8'hFF, x, good);
    check("big_model", good, 1);
    check("big_done", done, 1);
    check("big_cpu_rst_n", cpu_rst_n, 1);
    check("big_small_rejects", s_error, 1);
    for (int a = 0; a < 4096; a++) begin
      address = 12'(a);
      #1;
      check($sformatf("big_rd_%0d", a), d_bus, exp_dbus(a));
    end

    // Reload from RUN drops CPU reset on the same edge
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    model_run = 0;
    check("reload_cpu_rst_n", cpu_rst_n, 0);
    check("reload_done", done, 0);
    check("reload_ready", rx_ready, 1);

    // Asynchronous reset mid-payload
    send_byte(8'h00);
    send_byte(8'h0A);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom));
    #2;
    rst_n = 1'b0;
    #1;
    address = 12'h000;
    #1;
    check("rst_rx_ready", rx_ready, 0);
    check("rst_cpu_rst_n", cpu_rst_n, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_d_bus", d_bus, 8'h00);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    check("post_rst_ready", rx_ready, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
